control_pipe: RTL and testbench

Carries the 9-bit control word produced by the ID-stage control decoder down the ID/EX, EX/MEM and MEM/WB pipeline registers, giving each stage its control fields one cycle after the previous stage. It also detects load-use hazards, inserts bubbles, and flushes on a taken `beq` resolved in MEM. It sits between the control decoder and the datapath's EX, MEM and WB stages. It also drives the stall and flush controls of the PC and IF/ID registers.

---
 rtl/control_pipe.sv | 128 ++++++++++++
 tb/tb_control_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// control_pipe: carries the 9-bit control word {EX[3:0], MEM[2:0], WB[1:0]}
// through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use
// hazards, which insert one bubble, and handles a taken beq resolved in MEM,
// which flushes the two younger instructions.
module control_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] cont_id,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic [4:0] rd_id,
  input  logic       alu_zero_ex,
  output logic       reg_dst_ex,
  output logic [1:0] alu_op_ex,
  output logic       alu_src_ex,
  output logic       branch_mem,
  output logic       mem_read_mem,
  output logic       mem_write_mem,
  output logic       reg_write_wb,
  output logic       mem_to_reg_wb,
  output logic [4:0] wreg_mem,
  output logic [4:0] wreg_wb,
  output logic       stall,
  output logic       pcsrc,
  output logic       flush_ifid
);

  // ID/EX register
  logic [3:0] ex_ex;
  logic [2:0] mem_ex;
  logic [1:0] wb_ex;
  logic [4:0] rt_ex;
  logic [4:0] rd_ex;

  // EX/MEM register
  logic [2:0] mem_mem;
  logic [1:0] wb_mem;
  logic       zero_mem;
  logic [4:0] wreg_mem_q;

  // MEM/WB register
  logic [1:0] wb_wb;
  logic [4:0] wreg_wb_q;

  logic [4:0] wreg_ex;
  logic       hazard;

  // Destination register of the EX instruction: rd for R-format, rt otherwise.
  assign wreg_ex = ex_ex[3] ? rd_ex : rt_ex;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // $zero is never a real dependency.
  assign hazard = mem_ex[1] & (rt_ex != 5'd0) &
                  ((rt_ex == rs_id) | (rt_ex == rt_id));

  // A taken branch kills everything younger, so flush wins over stall.
  assign pcsrc      = mem_mem[2] & zero_mem;
  assign stall      = hazard & ~pcsrc;
  assign flush_ifid = pcsrc;

  // Stage outputs are taken directly from the pipeline registers.
  assign reg_dst_ex    = ex_ex[3];
  assign alu_op_ex     = ex_ex[2:1];
  assign alu_src_ex    = ex_ex[0];
  assign branch_mem    = mem_mem[2];
  assign mem_read_mem  = mem_mem[1];
  assign mem_write_mem = mem_mem[0];
  assign reg_write_wb  = wb_wb[1];
  assign mem_to_reg_wb = wb_wb[0];
  assign wreg_mem      = wreg_mem_q;
  assign wreg_wb       = wreg_wb_q;

  // Pipeline register update: reset > flush > stall > normal advance.
  // NOTE: every register here uses <= so that each stage reads the value its
  // predecessor held before this edge; blocking writes would let one
  // instruction fall through several stages in a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ex      <= '0;
      mem_ex     <= '0;
      wb_ex      <= '0;
      rt_ex      <= '0;
      rd_ex      <= '0;
      mem_mem    <= '0;
      wb_mem     <= '0;
      zero_mem   <= 1'b0;
      wreg_mem_q <= '0;
      wb_wb      <= '0;
      wreg_wb_q  <= '0;
    end else begin
      // MEM/WB always advances; a taken branch still retires with WB=00.
      wb_wb     <= wb_mem;
      wreg_wb_q <= wreg_mem_q;

      if (pcsrc) begin
        ex_ex      <= '0;
        mem_ex     <= '0;
        wb_ex      <= '0;
        rt_ex      <= '0;
        rd_ex      <= '0;
        mem_mem    <= '0;
        wb_mem     <= '0;
        zero_mem   <= 1'b0;
        wreg_mem_q <= '0;
      end else begin
        mem_mem    <= mem_ex;
        wb_mem     <= wb_ex;
        zero_mem   <= alu_zero_ex;
        wreg_mem_q <= wreg_ex;
        if (stall) begin
          // Bubble: the held IF/ID re-presents the same cont_id next cycle.
          ex_ex  <= '0;
          mem_ex <= '0;
          wb_ex  <= '0;
          rt_ex  <= '0;
          rd_ex  <= '0;
        end else begin
          ex_ex  <= cont_id[8:5];
          mem_ex <= cont_id[4:2];
          wb_ex  <= cont_id[1:0];
          rt_ex  <= rt_id;
          rd_ex  <= rd_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// Testbench for control_pipe. The stimulus drives directed instruction
// sequences and queues the expected output values, each tagged with the
// clock edge after which the value must be visible. A monitor samples on the
// falling edge, pops the entries that are due and compares them.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] cont_id;
  logic [4:0] rs_id, rt_id, rd_id;
  logic       alu_zero_ex;
  logic       reg_dst_ex, alu_src_ex, branch_mem, mem_read_mem, mem_write_mem;
  logic [1:0] alu_op_ex;
  logic       reg_write_wb, mem_to_reg_wb, stall, pcsrc, flush_ifid;
  logic [4:0] wreg_mem, wreg_wb;

  localparam logic [8:0] C_NOP = 9'b0000_000_00;
  localparam logic [8:0] C_R   = 9'b1100_000_10;
  localparam logic [8:0] C_LW  = 9'b0001_010_11;
  localparam logic [8:0] C_SW  = 9'b0001_001_00;
  localparam logic [8:0] C_BEQ = 9'b0010_100_00;

  control_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .cont_id       (cont_id),
    .rs_id         (rs_id),
    .rt_id         (rt_id),
    .rd_id         (rd_id),
    .alu_zero_ex   (alu_zero_ex),
    .reg_dst_ex    (reg_dst_ex),
    .alu_op_ex     (alu_op_ex),
    .alu_src_ex    (alu_src_ex),
    .branch_mem    (branch_mem),
    .mem_read_mem  (mem_read_mem),
    .mem_write_mem (mem_write_mem),
    .reg_write_wb  (reg_write_wb),
    .mem_to_reg_wb (mem_to_reg_wb),
    .wreg_mem      (wreg_mem),
    .wreg_wb       (wreg_wb),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .flush_ifid    (flush_ifid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Queue an expectation, keeping the scoreboard ordered by edge.
  task automatic expect_at(input int cyc, input string name, input logic [4:0] val);
    exp_t e;
    int   i;
    e.cyc  = cyc;
    e.name = name;
    e.val  = val;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= cyc) i++;
    sb.insert(i, e);
  endtask

  task automatic expect_zero_all(input int cyc);
    expect_at(cyc, "reg_dst_ex", 0);    expect_at(cyc, "alu_op_ex", 0);
    expect_at(cyc, "alu_src_ex", 0);    expect_at(cyc, "branch_mem", 0);
    expect_at(cyc, "mem_read_mem", 0);  expect_at(cyc, "mem_write_mem", 0);
    expect_at(cyc, "reg_write_wb", 0);  expect_at(cyc, "mem_to_reg_wb", 0);
    expect_at(cyc, "wreg_mem", 0);      expect_at(cyc, "wreg_wb", 0);
    expect_at(cyc, "stall", 0);         expect_at(cyc, "pcsrc", 0);
    expect_at(cyc, "flush_ifid", 0);
  endtask

  function automatic logic [4:0] observe(input string name);
    if (name == "reg_dst_ex")    return {4'b0, reg_dst_ex};
    if (name == "alu_op_ex")     return {3'b0, alu_op_ex};
    if (name == "alu_src_ex")    return {4'b0, alu_src_ex};
    if (name == "branch_mem")    return {4'b0, branch_mem};
    if (name == "mem_read_mem")  return {4'b0, mem_read_mem};
    if (name == "mem_write_mem") return {4'b0, mem_write_mem};
    if (name == "reg_write_wb")  return {4'b0, reg_write_wb};
    if (name == "mem_to_reg_wb") return {4'b0, mem_to_reg_wb};
    if (name == "wreg_mem")      return wreg_mem;
    if (name == "wreg_wb")       return wreg_wb;
    if (name == "stall")         return {4'b0, stall};
    if (name == "pcsrc")         return {4'b0, pcsrc};
    if (name == "flush_ifid")    return {4'b0, flush_ifid};
    return 5'bx;
  endfunction

  // Monitor: compare every expectation that is due after the latest edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
      cur = sb.pop_front();
      checks++;
      if (cur.cyc < edge_cnt) begin
        errors++;
        $display("FAIL %s: expectation for edge %0d never sampled (now edge %0d)",
                 cur.name, cur.cyc, edge_cnt);
      end else if (observe(cur.name) !== cur.val) begin
        errors++;
        $display("FAIL %s @edge %0d: got %0d, expected %0d",
                 cur.name, cur.cyc, observe(cur.name), cur.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID and let the next edge sample it.
  task automatic issue(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic z);
    cont_id     = c;
    rs_id       = rs;
    rt_id       = rt;
    rd_id       = rd;
    alu_zero_ex = z;
    tick();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 0, 0, 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;

    // 1. Reset with an all-ones control word presented.
    rst = 1'b1;
    cont_id = 9'h1FF; rs_id = 5'd31; rt_id = 5'd31; rd_id = 5'd31; alu_zero_ex = 1'b1;
    tick();
    expect_zero_all(edge_cnt + 1);
    tick();
    rst = 1'b0;
    nops(2);

    // 2. R-format flow: EX, then MEM, then WB, one edge apart.
    b = edge_cnt + 1;
    expect_at(b,     "reg_dst_ex", 1);  expect_at(b,     "alu_op_ex", 2);
    expect_at(b,     "alu_src_ex", 0);
    expect_at(b + 1, "mem_read_mem", 0); expect_at(b + 1, "mem_write_mem", 0);
    expect_at(b + 1, "wreg_mem", 5);     expect_at(b + 1, "reg_dst_ex", 0);
    expect_at(b + 2, "reg_write_wb", 1); expect_at(b + 2, "mem_to_reg_wb", 0);
    expect_at(b + 2, "wreg_wb", 5);
    issue(C_R, 5'd1, 5'd2, 5'd5, 1'b0);
    nops(3);

    // 3a. Load-use hazard: LW r8, then R-type reading r8 -> one bubble.
    b = edge_cnt + 1;
    expect_at(b,     "stall", 1);        expect_at(b,     "alu_src_ex", 1);
    expect_at(b + 1, "stall", 0);        expect_at(b + 1, "reg_dst_ex", 0);
    expect_at(b + 1, "mem_read_mem", 1); expect_at(b + 1, "wreg_mem", 8);
    expect_at(b + 2, "reg_dst_ex", 1);   expect_at(b + 2, "mem_read_mem", 0);
    expect_at(b + 2, "reg_write_wb", 1); expect_at(b + 2, "mem_to_reg_wb", 1);
    expect_at(b + 2, "wreg_wb", 8);
    expect_at(b + 3, "reg_write_wb", 0); expect_at(b + 3, "wreg_wb", 0);
    expect_at(b + 3, "wreg_mem", 10);
    expect_at(b + 4, "reg_write_wb", 1); expect_at(b + 4, "wreg_wb", 10);
    issue(C_LW, 5'd3, 5'd8, 5'd0, 1'b0);
    issue(C_R, 5'd8, 5'd9, 5'd10, 1'b0);
    issue(C_R, 5'd8, 5'd9, 5'd10, 1'b0);
    nops(4);

    // 3b. LW to r0 followed by a reader of r0: no stall.
    b = edge_cnt + 1;
    expect_at(b,     "stall", 0);
    expect_at(b + 1, "reg_dst_ex", 1);  expect_at(b + 1, "mem_read_mem", 1);
    issue(C_LW, 5'd3, 5'd0, 5'd0, 1'b0);
    issue(C_R, 5'd0, 5'd0, 5'd10, 1'b0);
    nops(3);

    // 4a. Taken beq: flush the younger LW (in EX) and SW (in ID).
    b = edge_cnt + 1;
    expect_at(b + 1, "pcsrc", 1);        expect_at(b + 1, "flush_ifid", 1);
    expect_at(b + 1, "branch_mem", 1);   expect_at(b + 1, "stall", 0);
    expect_at(b + 2, "mem_read_mem", 0); expect_at(b + 2, "wreg_mem", 0);
    expect_at(b + 2, "branch_mem", 0);   expect_at(b + 2, "pcsrc", 0);
    expect_at(b + 2, "flush_ifid", 0);   expect_at(b + 2, "alu_src_ex", 0);
    expect_at(b + 2, "reg_write_wb", 0);
    expect_at(b + 3, "mem_write_mem", 0);
    issue(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(C_LW, 5'd3, 5'd8, 5'd0, 1'b1);
    issue(C_SW, 5'd1, 5'd2, 5'd0, 1'b0);
    nops(3);

    // 4b. Same beq not taken: no flush, younger instructions proceed.
    b = edge_cnt + 1;
    expect_at(b + 1, "pcsrc", 0);        expect_at(b + 1, "flush_ifid", 0);
    expect_at(b + 1, "branch_mem", 1);
    expect_at(b + 2, "mem_read_mem", 1); expect_at(b + 2, "wreg_mem", 8);
    expect_at(b + 3, "mem_write_mem", 1);
    issue(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(C_LW, 5'd3, 5'd8, 5'd0, 1'b0);
    issue(C_SW, 5'd1, 5'd2, 5'd0, 1'b0);
    nops(3);

    // 5. Hazard and taken branch together: flush wins, stall stays low.
    b = edge_cnt + 1;
    expect_at(b + 1, "stall", 0);        expect_at(b + 1, "pcsrc", 1);
    expect_at(b + 1, "mem_read_mem", 0);
    expect_at(b + 2, "reg_dst_ex", 0);   expect_at(b + 2, "alu_op_ex", 0);
    expect_at(b + 2, "mem_read_mem", 0); expect_at(b + 2, "wreg_mem", 0);
    expect_at(b + 2, "stall", 0);        expect_at(b + 2, "pcsrc", 0);
    issue(C_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(C_LW, 5'd3, 5'd8, 5'd0, 1'b1);
    issue(C_R, 5'd8, 5'd9, 5'd10, 1'b0);
    nops(3);

    // 6. Reset with three instructions in flight discards them all.
    b = edge_cnt + 1;
    expect_at(b + 2, "reg_write_wb", 1); expect_at(b + 2, "wreg_wb", 5);
    expect_at(b + 2, "mem_read_mem", 1); expect_at(b + 2, "wreg_mem", 8);
    expect_at(b + 2, "reg_dst_ex", 1);
    expect_zero_all(b + 3);
    expect_zero_all(b + 4);
    issue(C_R, 5'd1, 5'd2, 5'd5, 1'b0);
    issue(C_LW, 5'd3, 5'd8, 5'd0, 1'b0);
    issue(C_R, 5'd4, 5'd6, 5'd12, 1'b0);
    rst = 1'b1;
    issue(C_LW, 5'd8, 5'd8, 5'd0, 1'b1);
    rst = 1'b0;
    nops(3);

    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d left unchecked", cur.name, cur.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
